// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_t;

  function automatic logic is_div(input md_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input md_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input md_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input md_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide: one bit per cycle over a shared 2*WIDTH register.
// state | meaning:  IDLE accept op | CALC shift-add / shift-subtract | FIX sign-correct | DONE hold result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t          r_state;
  md_op_t             r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_dbz;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_a_raw;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;

  md_op_t             w_op;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_min;
  logic               w_dbz;
  logic               w_ovf;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_trial;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_result;

  assign w_op    = md_op_t'(md_op);
  assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_sa    = is_signed_a(w_op) & a[WIDTH-1];
  assign w_sb    = is_signed_b(w_op) & b[WIDTH-1];
  assign w_mag_a = w_sa ? -a : a;
  assign w_mag_b = w_sb ? -b : b;
  assign w_dbz   = is_div(w_op) && (b == '0);
  assign w_ovf   = ((w_op == OP_DIV) || (w_op == OP_REM)) && (a == w_min) && (b == '1);

  // Multiply: accumulator high half gathers partial sums, low half holds the shifting multiplier.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_trial - {1'b0, r_mag_b};
  assign w_div_ok    = ~w_div_diff[WIDTH];
  assign w_div_next  = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_trial[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ok};

  assign w_prod_s = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quo    = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_result = '0;
    if (r_dbz) begin
      w_fix_result = is_rem(r_op) ? r_a_raw : '1;
    end else if (r_ovf) begin
      w_fix_result = is_rem(r_op) ? '0 : w_min;
    end else begin
      case (r_op)
        OP_MUL:                      w_fix_result = w_prod_s[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_s[2*WIDTH-1:WIDTH];
        OP_DIV, OP_DIVU:             w_fix_result = (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
        OP_REM, OP_REMU:             w_fix_result = r_sign_a ? -w_rem : w_rem;
        default:                     w_fix_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_MUL;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_a_raw     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (kill) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op     <= w_op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_a_raw  <= a;
            r_dbz    <= w_dbz;
            r_ovf    <= w_ovf;
            r_cnt    <= CW'(WIDTH);
            r_acc    <= is_div(w_op) ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_state  <= (w_dbz || w_ovf) ? FIX : CALC;
          end
        end
        CALC: begin
          r_acc <= is_div(r_op) ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result    <= w_fix_result;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with an arithmetic reference model and latency tracking.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   md_op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         kill = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .md_op(md_op), .a(a), .b(b), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    if (op[2] && bv == 32'd0) return 1'b1;
    if ((op == 3'b100 || op == 3'b110) && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] ua, up;
    int signed q;
    sa = 64'($signed(av));
    sb = 64'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin up = ua * ua; up = ua * {32'd0, bv}; return up[63:32]; end
      3'b100: begin
        if (bv == 0) return 32'hFFFF_FFFF;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(av) / $signed(bv);
        return q;
      end
      3'b101: return (bv == 0) ? 32'hFFFF_FFFF : av / bv;
      3'b110: begin
        if (bv == 0) return av;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'd0;
        q = $signed(av) % $signed(bv);
        return q;
      end
      default: return (bv == 0) ? av : av % bv;
    endcase
  endfunction

  // Scoreboard: one op in flight at most; tracks expected value and latency from acceptance.
  logic        pending = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] m_exp = '0;
  int          m_acc_cyc = 0;
  int          m_exp_lat = 0;

  always @(negedge clk) begin
    if (rst) begin
      pending    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!pending) check("valid_with_op_in_flight", 64'(pending), 64'd1);
        else begin
          check("model_result", 64'(result), 64'(m_exp));
          if (!prev_valid) check("latency", 64'(cyc - m_acc_cyc), 64'(m_exp_lat));
        end
      end
      prev_valid = out_valid;
      if (kill) begin
        pending    = 1'b0;
        prev_valid = 1'b0;
      end else if (out_valid && out_ready) begin
        pending = 1'b0;
      end
      if (in_valid && in_ready && !kill) begin
        pending   = 1'b1;
        m_exp     = model(md_op, a, b);
        m_acc_cyc = cyc;
        m_exp_lat = is_special(md_op, a, b) ? 2 : W + 2;
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_lit, input string name);
    int t;
    md_op    = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 100);
    if (!out_valid) check({name, "_timeout"}, 64'd0, 64'd1);
    else check(name, 64'(result), 64'(exp_lit));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] ex;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] held;
    logic        saw_valid;
    int          t;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,          32'd14};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,          32'd2};
    vecs[8]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{3'b110, 32'd5,          32'd0,          32'd5};
    vecs[10] = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[13] = '{3'b111, 32'd5,          32'd0,          32'd5};
    vecs[14] = '{3'b000, 32'h1234_5678, 32'h10,         32'h2345_6780};
    vecs[15] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

    #1 rst = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      check($sformatf("model_pin%0d", i), 64'(model(vecs[i].op, vecs[i].av, vecs[i].bv)), 64'(vecs[i].ex));
      do_op(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].ex, $sformatf("vec%0d", i));
    end

    // Backpressure with a competing request while DONE holds
    out_ready = 1'b0;
    md_op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 100);
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    held = result;
    check("bp_result", 64'(held), 64'hFFFF_FFFE);
    md_op = 3'b000; a = 32'd3; b = 32'd3; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_result", 64'(result), 64'(held));
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_valid_held", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    check("bp_valid_cleared", 64'(out_valid), 64'd0);

    // Kill mid-CALC
    md_op = 3'b000; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_in_ready", 64'(in_ready), 64'd1);
    check("kill_out_valid", 64'(out_valid), 64'd0);
    saw_valid = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) saw_valid = 1'b1; end
    check("kill_no_valid", 64'(saw_valid), 64'd0);
    @(posedge clk);
    #1;
    do_op(3'b101, 32'd9, 32'd3, 32'd3, "after_kill_divu");

    // Kill together with in_valid in IDLE
    md_op = 3'b000; a = 32'd2; b = 32'd2; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; kill = 1'b0;
    check("kill_accept_in_ready", 64'(in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) saw_valid = 1'b1; end
    check("kill_accept_no_valid", 64'(saw_valid), 64'd0);

    // Kill in DONE with out_ready discards the result
    @(posedge clk);
    #1;
    md_op = 3'b100; a = 32'd5; b = 32'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 100);
    check("kill_done_valid_seen", 64'(out_valid), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_done_out_valid", 64'(out_valid), 64'd0);
    check("kill_done_in_ready", 64'(in_ready), 64'd1);

    // Async reset between edges, mid-CALC
    do_op(3'b101, 32'd9, 32'd3, 32'd3, "pre_reset_divu");
    md_op = 3'b000; a = 32'hFFFF; b = 32'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(3'b000, 32'd6, 32'd7, 32'd42, "post_reset_mul");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M-style operation set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over a configurable data width. It sits beside the single-cycle ALU in the execute stage. It takes operands through a valid/ready handshake and returns a registered result after a fixed, op-independent latency, except for divide special cases, which finish early. It supports a kill input so the core can abandon an in-flight operation on a flush.

## Interface
Parameters:
- WIDTH, 32, operand/result width; legal values are even and ≥ 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; high iff state is IDLE.
- md_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU (funct3 encoding).
- a  in  WIDTH  operand A (dividend / multiplicand).
- b  in  WIDTH  operand B (divisor / multiplier).
- kill  in  1  synchronous abort of any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: if in_valid && !kill, latch op, the sign flags, and the magnitudes |a| and |b|. Signedness is applied per op:
  - MULHSU treats only a as signed.
  - Unsigned ops take raw values.
- IDLE transitions:
  - to FIX if op is a divide/remainder and b == 0, or if op is DIV/REM with a == MIN and b == −1 (special case);
  - otherwise to CALC, with the iteration counter set to WIDTH.
- CALC, one bit per cycle:
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder magnitudes.
  - Leave CALC when the counter reaches 0.
- FIX computes and registers the result:
  - MUL takes the low half of the signed product. MULH, MULHSU and MULHU take the high half. The product is negated when sign_a ^ sign_b, which applies only to the signed operands.
  - DIV quotient is negated if sign_a ^ sign_b. REM remainder takes the sign of a. DIVU/REMU are unsigned.
  - Divide by zero: quotient is all ones, remainder is a.
  - Overflow (MIN / −1): quotient is MIN, remainder is 0.
- DONE: out_valid = 1. On out_ready, go to IDLE. result is held stable while out_valid && !out_ready.
- No overlap: a new operation is accepted only in IDLE, the cycle after the DONE handshake.
- kill: from any state, go to IDLE on the next edge and clear out_valid. kill in the same cycle as in_valid suppresses acceptance. kill in DONE with out_ready counts as a kill; the result is discarded.
- Reset values: state IDLE; out_valid 0; result 0; internal accumulators and counter 0. in_ready reads 1 while in reset.

## Timing
- Acceptance occurs at edge T (in_valid && in_ready high in the cycle before T).
- Normal path: CALC occupies WIDTH cycles, then FIX one cycle. out_valid rises in the cycle after T+WIDTH+1, giving latency WIDTH+2 cycles (34 for WIDTH=32) for every non-special op.
- Special divide path: IDLE→FIX→DONE, so out_valid is high 2 cycles after acceptance.
- in_ready is combinational from state only, with no path from in_valid. out_valid and result are registers.
- Reset asserted mid-operation discards all state immediately. Deassertion returns the unit to IDLE.

## Structure
- Package muldiv_pkg holds:
  - the enum md_op_t (3-bit, the encodings above);
  - the enum md_state_t {IDLE, CALC, FIX, DONE};
  - helpers is_div(op) and is_signed_a/b(op).
- Single module: the shared 2·WIDTH shift register serves both multiply and divide, so no sub-module is needed.
- Counter width is $clog2(WIDTH+1).

## Test plan
All scenarios use WIDTH=32.
- MUL 7 × −3 (0xFFFFFFFD) → result 0xFFFFFFEB, out_valid exactly 34 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; all at 34-cycle latency.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIVU 5/0 → 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - All with out_valid 2 cycles after accept.
- Backpressure: hold out_ready low for 5 cycles after out_valid. result stays stable, in_ready stays 0, and a concurrent in_valid is not accepted. After the handshake, in_ready is 1 the next cycle.
- kill asserted 10 cycles into CALC → out_valid never rises and in_ready is 1 on the next cycle. The next op (DIVU 9/3) returns 3 with correct latency. kill together with in_valid in IDLE → no acceptance.
- Async rst pulsed mid-CALC, between clock edges → out_valid 0 and result 0 immediately. After release, a fresh MUL 6×7 returns 42.
